// File: rtl/ddr_a2m_cmdsched.sv
// ddr_a2m_cmdsched: pops AXI requests from the request FIFO and splits
// them into MBA commands, throttling outstanding read commands.
// Ports: CLK/ZRESET; FIFO side EMPTY, RE, AX* show-ahead head fields;
// command side CMDVALID/CMDREADY, CMD* fields; RDDONE (read return pulse)
// and BUSY. Optional macro DDR_A2M_CMDSCHED_EXCL_EN: unsplit, drained
// exclusive commands with CMDLOCK.
module ddr_a2m_cmdsched #(
  parameter int P_IW    = 8,
  parameter int P_AW    = 40,
  parameter int P_MBL   = 16,
  parameter int P_MAXRD = 4
) (
  input  logic            CLK,
  input  logic            ZRESET,
  input  logic            EMPTY,
  output logic            RE,
  input  logic [P_IW-1:0] AXID,
  input  logic [P_AW-1:0] AXADDR,
  input  logic [7:0]      AXLEN,
  input  logic [2:0]      AXSIZE,
  input  logic [1:0]      AXBURST,
  input  logic            AXLOCK,
  input  logic            AXDIR,
  output logic            CMDVALID,
  input  logic            CMDREADY,
  output logic [P_IW-1:0] CMDID,
  output logic [P_AW-1:0] CMDADDR,
  output logic [7:0]      CMDLEN,
  output logic [2:0]      CMDSIZE,
  output logic            CMDDIR,
  output logic            CMDWRAP,
  output logic            CMDLOCK,
  output logic            CMDLAST,
  input  logic            RDDONE,
  output logic            BUSY
);

  localparam int         MW       = $clog2(P_MBL);
  localparam logic [3:0] MAXRD    = 4'(P_MAXRD);
  localparam logic [8:0] MBL      = 9'(P_MBL);
  localparam logic [1:0] BT_FIXED = 2'd0;
  localparam logic [1:0] BT_WRAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_ISSUE
  } state_t;

  state_t state, state_nx;

  logic [P_AW-1:0] addr;
  logic [P_AW-1:0] step;
  logic [7:0]      rem;
  logic [P_IW-1:0] id;
  logic [2:0]      size;
  logic [1:0]      burst;
  logic            dir;
  logic [3:0]      rdcnt;
  logic            lk;
  logic            pop_ok;
  logic            go;
  logic            fire;
  logic            rd_inc;
  logic            rd_dec;
  logic [MW-1:0]   off;
  logic [8:0]      rem1;
  logic [8:0]      space;
  logic [8:0]      n;

`ifdef DDR_A2M_CMDSCHED_EXCL_EN
  logic lock;
  logic excl_wait;

  assign lk     = lock;
  // After a locked command, hold off the next pop until reads drain.
  assign pop_ok = !excl_wait || (rdcnt == 4'd0);
  assign go     = (dir || (rdcnt < MAXRD))
               && (!lock || (rdcnt == 4'd0));

  always_ff @(posedge CLK or negedge ZRESET) begin
    if (!ZRESET) begin
      lock      <= 1'b0;
      excl_wait <= 1'b0;
    end else begin
      if (RE)
        lock <= AXLOCK;
      if (fire && CMDLOCK)
        excl_wait <= 1'b1;
      else if (rdcnt == 4'd0)
        excl_wait <= 1'b0;
    end
  end
`else
  logic unused_axlock;

  assign unused_axlock = AXLOCK;
  assign lk            = 1'b0;
  assign pop_ok        = 1'b1;
  assign go            = dir || (rdcnt < MAXRD);
`endif

  assign fire  = (state == S_ISSUE) && CMDREADY;
  assign off   = MW'(addr >> size);
  assign rem1  = {1'b0, rem} + 9'd1;
  assign space = MBL - 9'(off);
  assign step  = P_AW'({1'b0, CMDLEN} + 9'd1);

  // Chunk size: INCR stops at the P_MBL-beat window boundary.
  always_comb begin
    n = 9'd1;
    unique case (1'b1)
      lk:                          n = rem1;
      !lk && burst == BT_FIXED:    n = 9'd1;
      !lk && burst == BT_WRAP:     n = rem1;
      default: n = (rem1 < space) ? rem1 : space;
    endcase
  end

  always_ff @(posedge CLK or negedge ZRESET) begin
    if (!ZRESET)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (RE) state_nx = S_HOLD;
      S_HOLD:  if (go) state_nx = S_ISSUE;
      S_ISSUE: begin
        if (CMDREADY)
          state_nx = CMDLAST ? S_IDLE : S_HOLD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    RE       = (state == S_IDLE) && !EMPTY && pop_ok;
    CMDVALID = (state == S_ISSUE);
    BUSY     = (state != S_IDLE) || (rdcnt != 4'd0);
  end

  always_ff @(posedge CLK or negedge ZRESET) begin
    if (!ZRESET) begin
      addr    <= '0;
      rem     <= '0;
      id      <= '0;
      size    <= '0;
      burst   <= '0;
      dir     <= 1'b0;
      CMDID   <= '0;
      CMDADDR <= '0;
      CMDLEN  <= '0;
      CMDSIZE <= '0;
      CMDDIR  <= 1'b0;
      CMDWRAP <= 1'b0;
      CMDLOCK <= 1'b0;
      CMDLAST <= 1'b0;
    end else begin
      if (RE) begin
        addr  <= AXADDR;
        rem   <= AXLEN;
        id    <= AXID;
        size  <= AXSIZE;
        burst <= AXBURST;
        dir   <= AXDIR;
      end else if (fire) begin
        rem <= rem - CMDLEN - 8'd1;
        if (burst != BT_FIXED)
          addr <= addr + (step << size);
      end
      if (state == S_HOLD && go) begin
        CMDID   <= id;
        CMDADDR <= addr;
        CMDLEN  <= 8'(n - 9'd1);
        CMDSIZE <= size;
        CMDDIR  <= dir;
        CMDWRAP <= (burst == BT_WRAP);
        CMDLOCK <= lk;
        CMDLAST <= (n == rem1);
      end
    end
  end

  // Spurious RDDONE at zero is dropped; the count never passes P_MAXRD.
  assign rd_inc = fire && !CMDDIR;
  assign rd_dec = RDDONE && (rdcnt != 4'd0);

  always_ff @(posedge CLK or negedge ZRESET) begin
    if (!ZRESET)
      rdcnt <= '0;
    else if (rd_inc && !rd_dec && rdcnt < MAXRD)
      rdcnt <= rdcnt + 4'd1;
    else if (rd_dec && !rd_inc)
      rdcnt <= rdcnt - 4'd1;
  end

endmodule

// File: tb/tb_ddr_a2m_cmdsched.sv
// tb_ddr_a2m_cmdsched: directed bench with FIFO model and command
// scoreboard for ddr_a2m_cmdsched (P_MBL=16, P_MAXRD=4).
module tb_ddr_a2m_cmdsched;

  typedef struct packed {
    logic [7:0]  id;
    logic [39:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic        dir;
  } req_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [39:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic        dir;
    logic        wrap;
    logic        lock;
    logic        last;
  } cmd_t;

  logic        CLK = 1'b0;
  logic        ZRESET;
  logic        EMPTY;
  logic        RE;
  logic [7:0]  AXID;
  logic [39:0] AXADDR;
  logic [7:0]  AXLEN;
  logic [2:0]  AXSIZE;
  logic [1:0]  AXBURST;
  logic        AXLOCK;
  logic        AXDIR;
  logic        CMDVALID;
  logic        CMDREADY;
  logic [7:0]  CMDID;
  logic [39:0] CMDADDR;
  logic [7:0]  CMDLEN;
  logic [2:0]  CMDSIZE;
  logic        CMDDIR;
  logic        CMDWRAP;
  logic        CMDLOCK;
  logic        CMDLAST;
  logic        RDDONE;
  logic        BUSY;

  req_t fq[$];
  cmd_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   re_cnt = 0;
  int   hs_cnt = 0;
  int   vld_cnt = 0;
  int   r0, h0, v0;

  ddr_a2m_cmdsched #(
    .P_IW(8), .P_AW(40), .P_MBL(16), .P_MAXRD(4)
  ) dut (
    .CLK(CLK), .ZRESET(ZRESET),
    .EMPTY(EMPTY), .RE(RE),
    .AXID(AXID), .AXADDR(AXADDR), .AXLEN(AXLEN),
    .AXSIZE(AXSIZE), .AXBURST(AXBURST),
    .AXLOCK(AXLOCK), .AXDIR(AXDIR),
    .CMDVALID(CMDVALID), .CMDREADY(CMDREADY),
    .CMDID(CMDID), .CMDADDR(CMDADDR), .CMDLEN(CMDLEN),
    .CMDSIZE(CMDSIZE), .CMDDIR(CMDDIR), .CMDWRAP(CMDWRAP),
    .CMDLOCK(CMDLOCK), .CMDLAST(CMDLAST),
    .RDDONE(RDDONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t cur();
    cmd_t c;
    c = {CMDID, CMDADDR, CMDLEN, CMDSIZE,
         CMDDIR, CMDWRAP, CMDLOCK, CMDLAST};
    return c;
  endfunction

  task automatic set_head();
    if (fq.size() == 0) begin
      EMPTY = 1'b1; AXID = '0; AXADDR = '0; AXLEN = '0;
      AXSIZE = '0; AXBURST = '0; AXLOCK = 1'b0; AXDIR = 1'b0;
    end else begin
      EMPTY   = 1'b0;
      AXID    = fq[0].id;
      AXADDR  = fq[0].addr;
      AXLEN   = fq[0].len;
      AXSIZE  = fq[0].size;
      AXBURST = fq[0].burst;
      AXLOCK  = fq[0].lock;
      AXDIR   = fq[0].dir;
    end
  endtask

  task automatic push_req(input logic [7:0] id,
                          input logic [39:0] addr,
                          input logic [7:0] len,
                          input logic [2:0] size,
                          input logic [1:0] burst,
                          input logic lock,
                          input logic dir);
    req_t r;
    r = {id, addr, len, size, burst, lock, dir};
    fq.push_back(r);
    set_head();
  endtask

  task automatic exp_cmd(input logic [7:0] id,
                         input logic [39:0] addr,
                         input logic [7:0] len,
                         input logic [2:0] size,
                         input logic dir,
                         input logic wrap,
                         input logic lock,
                         input logic last);
    cmd_t c;
    c = {id, addr, len, size, dir, wrap, lock, last};
    sb.push_back(c);
  endtask

  // One clock: called just after a negedge, returns at the next negedge.
  task automatic tick();
    logic re_s;
    cmd_t e;
    #1;
    re_s = RE;
    if (RE) re_cnt++;
    if (CMDVALID) vld_cnt++;
    chk("re_while_empty", 64'(RE & EMPTY), 64'd0);
    if (CMDVALID && CMDREADY) begin
      hs_cnt++;
      chk("sb_avail", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("cmd", 64'(cur()), 64'(e));
      end
    end
    @(posedge CLK);
    #1;
    if (re_s && fq.size() != 0) void'(fq.pop_front());
    set_head();
    @(negedge CLK);
  endtask

  task automatic lat(input string tag, input int want);
    int c = 0;
    while (!CMDVALID && c < 20) begin
      tick();
      c++;
    end
    chk(tag, 64'(c), 64'(want));
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while (sb.size() != 0 && c < 200) begin
      tick();
      c++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic rddone_pulse();
    RDDONE = 1'b1;
    tick();
    RDDONE = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},
        64'({RE, CMDVALID, BUSY, CMDID, CMDLEN, CMDSIZE,
             CMDDIR, CMDWRAP, CMDLOCK, CMDLAST}), 64'd0);
    chk({tag, "_addr"}, 64'(CMDADDR), 64'd0);
  endtask

  initial begin
    ZRESET = 1'b0;
    CMDREADY = 1'b1;
    RDDONE = 1'b0;
    set_head();
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk_zero("reset");
    @(negedge CLK);
    ZRESET = 1'b1;
    tick();

    // INCR write split on 16-beat windows
    r0 = re_cnt; h0 = hs_cnt;
    push_req(8'd1, 40'h40, 8'd31, 3'd3, 2'd1, 1'b0, 1'b1);
    exp_cmd(8'd1, 40'h40,  8'd7,  3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cmd(8'd1, 40'h80,  8'd15, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cmd(8'd1, 40'h100, 8'd7,  3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    lat("t1_latency", 2);
    drain("t1_drain");
    chk("t1_re_pulses", 64'(re_cnt - r0), 64'd1);
    chk("t1_cmds", 64'(hs_cnt - h0), 64'd3);

    // FIXED read: one beat per command, fills rdcnt to 4
    h0 = hs_cnt;
    push_req(8'd2, 40'h1000, 8'd3, 3'd2, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      exp_cmd(8'd2, 40'h1000, 8'd0, 3'd2, 1'b0, 1'b0, 1'b0,
              1'(i == 3));
    drain("t2_drain");
    chk("t2_cmds", 64'(hs_cnt - h0), 64'd4);

    // write not throttled at rdcnt=4, next read held
    push_req(8'd4, 40'h5000, 8'd0, 3'd2, 2'd1, 1'b0, 1'b1);
    exp_cmd(8'd4, 40'h5000, 8'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    drain("t3_write");
    push_req(8'd3, 40'h3000, 8'd0, 3'd2, 2'd1, 1'b0, 1'b0);
    exp_cmd(8'd3, 40'h3000, 8'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    v0 = vld_cnt;
    repeat (8) tick();
    chk("t3_held", 64'(vld_cnt - v0), 64'd0);
    chk("t3_busy", 64'(BUSY), 64'd1);
    rddone_pulse();
    chk("t3_rel_1", 64'(CMDVALID), 64'd0);
    tick();
    chk("t3_rel_2", 64'(CMDVALID), 64'd1);
    drain("t3_drain");

    // drain rdcnt, extra RDDONE must not underflow
    repeat (5) begin
      rddone_pulse();
      tick();
    end
    chk("t4_idle_busy", 64'(BUSY), 64'd0);

    // WRAP read: single command
    push_req(8'd5, 40'h2014, 8'd7, 3'd2, 2'd2, 1'b0, 1'b0);
    exp_cmd(8'd5, 40'h2014, 8'd7, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    drain("t4_wrap");
    tick();
    chk("t4_rd_busy", 64'(BUSY), 64'd1);

    // stall with CMDREADY low, then handshake with RDDONE
    CMDREADY = 1'b0;
    push_req(8'd6, 40'h0, 8'd3, 3'd0, 2'd1, 1'b0, 1'b0);
    exp_cmd(8'd6, 40'h0, 8'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    lat("t5_latency", 2);
    repeat (5) begin
      tick();
      chk("t5_valid", 64'(CMDVALID), 64'd1);
      chk("t5_fields", 64'(cur()), 64'(sb[0]));
    end
    CMDREADY = 1'b1;
    RDDONE = 1'b1;
    tick();
    RDDONE = 1'b0;
    chk("t5_hs", 64'(sb.size()), 64'd0);
    tick();
    chk("t5_cnt_keep", 64'(BUSY), 64'd1);
    rddone_pulse();
    chk("t5_cnt_zero", 64'(BUSY), 64'd0);

`ifdef DDR_A2M_CMDSCHED_EXCL_EN
    push_req(8'd10, 40'h6000, 8'd0, 3'd2, 2'd1, 1'b0, 1'b0);
    exp_cmd(8'd10, 40'h6000, 8'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("t6_pre");
    push_req(8'd11, 40'h40, 8'd31, 3'd3, 2'd1, 1'b1, 1'b0);
    exp_cmd(8'd11, 40'h40, 8'd31, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    v0 = vld_cnt;
    repeat (6) tick();
    chk("t6_lock_held", 64'(vld_cnt - v0), 64'd0);
    rddone_pulse();
    drain("t6_lock");
    push_req(8'd12, 40'h7000, 8'd0, 3'd2, 2'd1, 1'b0, 1'b1);
    exp_cmd(8'd12, 40'h7000, 8'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    r0 = re_cnt;
    repeat (4) tick();
    chk("t6_no_pop", 64'(re_cnt - r0), 64'd0);
    rddone_pulse();
    drain("t6_after");
    chk("t6_pop", 64'(re_cnt - r0), 64'd1);
`else
    push_req(8'd9, 40'h40, 8'd31, 3'd3, 2'd1, 1'b1, 1'b1);
    exp_cmd(8'd9, 40'h40,  8'd7,  3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cmd(8'd9, 40'h80,  8'd15, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_cmd(8'd9, 40'h100, 8'd7,  3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    drain("t6_lock_split");
`endif

    // reset after the first chunk discards the rest
    push_req(8'd7, 40'h40, 8'd31, 3'd3, 2'd1, 1'b0, 1'b1);
    exp_cmd(8'd7, 40'h40, 8'd7, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("t7_first");
    ZRESET = 1'b0;
    #1;
    chk_zero("t7_reset");
    @(negedge CLK);
    ZRESET = 1'b1;
    push_req(8'd8, 40'h40, 8'd0, 3'd3, 2'd1, 1'b0, 1'b1);
    exp_cmd(8'd8, 40'h40, 8'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    lat("t7_latency", 2);
    drain("t7_drain");
    v0 = vld_cnt;
    repeat (4) tick();
    chk("t7_quiet", 64'(vld_cnt - v0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
